// File: rtl/fetch_queue_pkg.sv
// Shared sizes, entry layout and reset PC for the fetch queue.
package fetch_queue_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned FETCH_LEN = 4;
    localparam int unsigned FETCH_OFF = 3;
    localparam int unsigned QUEUE_LEN = 8;
    localparam int unsigned MAX_OUTST = 4;

    localparam int unsigned PTR_W = $clog2(QUEUE_LEN);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
    // Wide enough to hold count + outstanding without overflow
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [XLEN-1:0] RESET_PC = 32'h200;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            err;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: one write port, FETCH_LEN read ports rotated from rd_ptr.
module fetch_queue_ram
    import fetch_queue_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [PTR_W-1:0]         waddr,
    input  entry_t                   wdata,
    input  logic [PTR_W-1:0]         rd_ptr,
    output entry_t [FETCH_LEN-1:0]   rdata
);

    entry_t mem_q [QUEUE_LEN];

    // Write port; contents need no reset since the window is gated by count
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports: entry i sits at rd_ptr + i with natural pointer wrap
    always_comb begin
        for (int i = 0; i < FETCH_LEN; i++) begin
            rdata[i] = mem_q[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential requests with credit flow control, in-order
// response buffering, FETCH_LEN-wide window, partial retire and jump flush.
// Optional zero-latency response bypass into an empty window: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvld,
    input  logic [XLEN-1:0]           imem_rdata,
    input  logic                      imem_err,
    output logic [FETCH_LEN-1:0]      fetch_vld,
    output logic [FETCH_LEN*XLEN-1:0] fetch_instr,
    output logic [FETCH_LEN*XLEN-1:0] fetch_pc,
    output logic [FETCH_LEN-1:0]      fetch_err,
    input  logic [FETCH_OFF-1:0]      fetch_offset,
    input  logic                      jump_vld,
    input  logic [XLEN-1:0]           jump_pc
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [OUT_W-1:0] drop_q, drop_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic             halted_q, halted_d;

    logic             issue, rsp_take, rsp_drop, push, byp;
    logic [CNT_W-1:0] pop;
    entry_t           rsp_entry;
    entry_t [FETCH_LEN-1:0] rd_entries;

    // Request credit, response classification and retire amount
    always_comb begin
        imem_req = ~rst & ~halted_q & ~jump_vld & (outst_q < OUT_W'(MAX_OUTST)) &
                   ((SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(QUEUE_LEN));
        issue    = imem_req & imem_gnt;
        rsp_take = imem_rvld & (drop_q == '0);
        rsp_drop = imem_rvld & (drop_q != '0);
        rsp_entry.instr = imem_err ? '0 : imem_rdata;
        rsp_entry.pc    = resp_pc_q;
        rsp_entry.err   = imem_err;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = rsp_take & ~jump_vld & (count_q == '0);
`else
        byp = 1'b0;
`endif
        // A bypassed word that the scheduler consumes at once is never stored
        push = rsp_take & ~jump_vld & ~(byp & (fetch_offset != '0));
        pop  = (CNT_W'(fetch_offset) > count_q) ? count_q : CNT_W'(fetch_offset);
    end

    // Next-state: jump flushes and redirects, otherwise push/pop/issue
    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        req_pc_d  = req_pc_q;
        resp_pc_d = resp_pc_q;
        halted_d  = halted_q;
        if (jump_vld) begin
            count_d   = '0;
            rd_ptr_d  = wr_ptr_q;
            outst_d   = outst_q - OUT_W'(imem_rvld);
            // Everything still in flight belongs to the old path
            drop_d    = outst_q - OUT_W'(imem_rvld);
            req_pc_d  = {jump_pc[XLEN-1:2], 2'b00};
            resp_pc_d = {jump_pc[XLEN-1:2], 2'b00};
            halted_d  = 1'b0;
        end else begin
            outst_d  = outst_q + OUT_W'(issue) - OUT_W'(imem_rvld);
            drop_d   = drop_q - OUT_W'(rsp_drop);
            if (issue) begin
                req_pc_d = req_pc_q + XLEN'(4);
            end
            if (rsp_take) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                if (imem_err) begin
                    halted_d = 1'b1;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_d = rd_ptr_q + pop[PTR_W-1:0];
            count_d  = count_q + CNT_W'(push) - pop;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            req_pc_q  <= RESET_PC;
            resp_pc_q <= RESET_PC;
            halted_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            req_pc_q  <= req_pc_d;
            resp_pc_q <= resp_pc_d;
            halted_q  <= halted_d;
        end
    end

    assign imem_addr = req_pc_q;

    fetch_queue_ram u_ram (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (rsp_entry),
        .rd_ptr (rd_ptr_q),
        .rdata  (rd_entries)
    );

    // Window: valid entries from the queue, zeros beyond count
    always_comb begin
        entry_t e;
        for (int i = 0; i < FETCH_LEN; i++) begin
            fetch_vld[i] = CNT_W'(i) < count_q;
            e = fetch_vld[i] ? rd_entries[i] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (byp && i == 0) begin
                fetch_vld[i] = 1'b1;
                e = rsp_entry;
            end
`endif
            fetch_instr[i*XLEN +: XLEN] = e.instr;
            fetch_pc[i*XLEN +: XLEN]    = e.pc;
            fetch_err[i]                = e.err;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order behavioural instruction memory.
module tb_fetch_queue;

    localparam logic [31:0] K = 32'hABCD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvld;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [3:0]  fetch_vld;
    logic [127:0] fetch_instr;
    logic [127:0] fetch_pc;
    logic [3:0]  fetch_err;
    logic [2:0]  fetch_offset;
    logic        jump_vld;
    logic [31:0] jump_pc;

    int checks = 0;
    int errors = 0;

    // Memory model state
    logic [31:0] pend[$];
    logic        mem_en;
    logic        gnt_en;
    logic        err_en;
    logic [31:0] err_addr;
    logic        ovr_en;
    logic [31:0] ovr_data;
    int          issued;

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvld    (imem_rvld),
        .imem_rdata   (imem_rdata),
        .imem_err     (imem_err),
        .fetch_vld    (fetch_vld),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .fetch_err    (fetch_err),
        .fetch_offset (fetch_offset),
        .jump_vld     (jump_vld),
        .jump_pc      (jump_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc_at(int i);
        return fetch_pc[i*32 +: 32];
    endfunction

    function automatic logic [31:0] instr_at(int i);
        return fetch_instr[i*32 +: 32];
    endfunction

    // Drive one cycle's inputs at the negedge and record any issued request
    task automatic drive(input int off, input logic jv, input logic [31:0] jpc);
        logic [31:0] a;
        fetch_offset = 3'(off);
        jump_vld     = jv;
        jump_pc      = jpc;
        imem_gnt     = gnt_en;
        if (mem_en && pend.size() > 0) begin
            a          = pend.pop_front();
            imem_rvld  = 1'b1;
            imem_rdata = ovr_en ? ovr_data : (a ^ K);
            imem_err   = err_en && (a == err_addr);
        end else begin
            imem_rvld  = 1'b0;
            imem_rdata = '0;
            imem_err   = 1'b0;
        end
        #1;
        if (!rst && !jump_vld && (int'(fetch_offset) > $countones(fetch_vld))) begin
            errors++;
            $display("FAIL offset_legal: offset %0d exceeds valid %0d", fetch_offset,
                     $countones(fetch_vld));
        end
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            issued++;
        end
    endtask

    // Advance through the edge, then return inputs to idle so outputs reflect state only
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        imem_rvld    = 1'b0;
        imem_err     = 1'b0;
        imem_rdata   = '0;
        fetch_offset = '0;
        jump_vld     = 1'b0;
        #1;
    endtask

    task automatic step(input int off, input logic jv, input logic [31:0] jpc);
        drive(off, jv, jpc);
        tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pend.delete();
        mem_en   = 1'b1;
        gnt_en   = 1'b1;
        err_en   = 1'b0;
        ovr_en   = 1'b0;
        issued   = 0;
        imem_gnt = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++;
            $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h200) begin errors++;
            $display("FAIL rst_addr: got %h want 00000200", imem_addr); end
        checks++; if (fetch_vld !== 4'b0000) begin errors++;
            $display("FAIL rst_vld: got %b want 0000", fetch_vld); end
        checks++; if (fetch_instr !== '0) begin errors++;
            $display("FAIL rst_instr: got %h want 0", fetch_instr); end
        checks++; if (fetch_pc !== '0) begin errors++;
            $display("FAIL rst_pc: got %h want 0", fetch_pc); end
        checks++; if (fetch_err !== 4'b0000) begin errors++;
            $display("FAIL rst_err: got %b want 0000", fetch_err); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int c = 0; c < 14; c++) step(0, 1'b0, '0);
        checks++; if (issued !== 8) begin errors++;
            $display("FAIL fill_issued: got %0d want 8", issued); end
        checks++; if (imem_req !== 1'b0) begin errors++;
            $display("FAIL fill_req: got %b want 0", imem_req); end
        checks++; if (fetch_vld !== 4'b1111) begin errors++;
            $display("FAIL fill_vld: got %b want 1111", fetch_vld); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc_at(i) !== 32'h200 + 32'(4 * i)) begin errors++;
                $display("FAIL fill_pc%0d: got %h want %h", i, pc_at(i), 32'h200 + 32'(4 * i));
            end
        end
        checks++; if (instr_at(0) !== 32'hABCD_0200) begin errors++;
            $display("FAIL fill_instr0: got %h want abcd0200", instr_at(0)); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = 32'h200;
        int nvld;
        for (int c = 0; c < 40; c++) begin
            nvld = $countones(fetch_vld);
            for (int i = 0; i < nvld; i++) begin
                checks++; if (pc_at(i) !== exp_pc || instr_at(i) !== (exp_pc ^ K)) begin
                    errors++;
                    $display("FAIL stream_pc: got %h/%h want %h/%h", pc_at(i), instr_at(i),
                             exp_pc, exp_pc ^ K);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (c >= 20) begin
                checks++; if (nvld != 1) begin errors++;
                    $display("FAIL stream_rate: got %0d words want 1", nvld); end
            end
            step(nvld, 1'b0, '0);
        end
    endtask

    task automatic test_jump();
        do_reset();
        rst    = 1'b0;
        mem_en = 1'b0;
        for (int c = 0; c < 3; c++) step(0, 1'b0, '0);
        gnt_en = 1'b0;
        checks++; if (issued !== 3) begin errors++;
            $display("FAIL jump_setup: got %0d want 3", issued); end
        drive(0, 1'b1, 32'h1003);
        checks++; if (imem_req !== 1'b0) begin errors++;
            $display("FAIL jump_req: got %b want 0", imem_req); end
        tick();
        checks++; if (fetch_vld !== 4'b0000) begin errors++;
            $display("FAIL jump_vld: got %b want 0000", fetch_vld); end
        checks++; if (imem_addr !== 32'h1000) begin errors++;
            $display("FAIL jump_addr: got %h want 00001000", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++;
            $display("FAIL jump_req_next: got %b want 1", imem_req); end
        mem_en = 1'b1;
        gnt_en = 1'b1;
        for (int c = 0; c < 10; c++) step(0, 1'b0, '0);
        checks++; if (pc_at(0) !== 32'h1000 || instr_at(0) !== 32'hABCD_1000) begin errors++;
            $display("FAIL jump_pc0: got %h/%h want 00001000/abcd1000", pc_at(0), instr_at(0));
        end
        checks++; if (pc_at(1) !== 32'h1004) begin errors++;
            $display("FAIL jump_pc1: got %h want 00001004", pc_at(1)); end
    endtask

    task automatic test_err();
        do_reset();
        rst      = 1'b0;
        err_en   = 1'b1;
        err_addr = 32'h20C;
        for (int c = 0; c < 10; c++) step(0, 1'b0, '0);
        checks++; if (fetch_err !== 4'b1000) begin errors++;
            $display("FAIL err_flags: got %b want 1000", fetch_err); end
        checks++; if (instr_at(3) !== 32'h0 || pc_at(3) !== 32'h20C) begin errors++;
            $display("FAIL err_entry: got %h/%h want 00000000/0000020c", instr_at(3), pc_at(3));
        end
        checks++; if (imem_req !== 1'b0 || issued !== 5) begin errors++;
            $display("FAIL err_halt: got req %b issued %0d want 0/5", imem_req, issued); end
        err_en = 1'b0;
        step(0, 1'b1, 32'h300);
        for (int c = 0; c < 8; c++) step(0, 1'b0, '0);
        checks++; if (pc_at(0) !== 32'h300 || instr_at(0) !== 32'hABCD_0300) begin errors++;
            $display("FAIL err_resume: got %h/%h want 00000300/abcd0300", pc_at(0), instr_at(0));
        end
        checks++; if (fetch_err !== 4'b0000) begin errors++;
            $display("FAIL err_clear: got %b want 0000", fetch_err); end
    endtask

    task automatic test_pop_push();
        do_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) step(0, 1'b0, '0);
        checks++; if (fetch_vld !== 4'b0111) begin errors++;
            $display("FAIL pp_pre: got %b want 0111", fetch_vld); end
        gnt_en = 1'b0;
        step(2, 1'b0, '0);
        checks++; if (fetch_vld !== 4'b0011) begin errors++;
            $display("FAIL pp_vld: got %b want 0011", fetch_vld); end
        checks++; if (pc_at(0) !== 32'h208 || pc_at(1) !== 32'h20C) begin errors++;
            $display("FAIL pp_pc: got %h,%h want 00000208,0000020c", pc_at(0), pc_at(1)); end
        checks++; if (instr_at(1) !== 32'hABCD_020C) begin errors++;
            $display("FAIL pp_instr: got %h want abcd020c", instr_at(1)); end
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        rst    = 1'b0;
        mem_en = 1'b0;
        step(0, 1'b0, '0);
        gnt_en   = 1'b0;
        mem_en   = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'h0000_0013;
        drive(1, 1'b0, '0);
        checks++; if (fetch_vld !== 4'b0001) begin errors++;
            $display("FAIL byp_vld: got %b want 0001", fetch_vld); end
        checks++; if (instr_at(0) !== 32'h13 || pc_at(0) !== 32'h200) begin errors++;
            $display("FAIL byp_entry: got %h/%h want 00000013/00000200", instr_at(0), pc_at(0));
        end
        tick();
        ovr_en = 1'b0;
        checks++; if (fetch_vld !== 4'b0000) begin errors++;
            $display("FAIL byp_count: got %b want 0000", fetch_vld); end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        imem_gnt     = 1'b0;
        imem_rvld    = 1'b0;
        imem_rdata   = '0;
        imem_err     = 1'b0;
        fetch_offset = '0;
        jump_vld     = 1'b0;
        jump_pc      = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_stream();
        test_jump();
        test_err();
        test_pop_push();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end directly upstream of the scheduling stage.
- Issues sequential word requests to the instruction memory port and buffers returned words with their PC and error flag.
- Presents the oldest FETCH_LEN entries as the fetch window (fetch_vld/instr/pc/err).
- Retires however many entries the scheduler reports consumed via fetch_offset; flushes and redirects on jump_vld.

Parameters:
XLEN, 32, instruction/PC width
FETCH_LEN, 4, window width presented to scheduler
FETCH_OFF, 3, width of fetch_offset; equals clog2(FETCH_LEN+1)
QUEUE_LEN, 8, entries in queue (power of 2, >= FETCH_LEN)
MAX_OUTST, 4, maximum in-flight memory requests
RESET_PC, 32'h200, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req  out  1  request valid
imem_addr  out  XLEN  word address of request (PC)
imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt = issued)
imem_rvld  in  1  response valid; responses return in order
imem_rdata  in  XLEN  response instruction word
imem_err  in  1  response carries access fault
fetch_vld  out  FETCH_LEN  window entry valid, contiguous from bit 0
fetch_instr  out  FETCH_LEN*XLEN  window instructions, entry 0 oldest
fetch_pc  out  FETCH_LEN*XLEN  window PCs
fetch_err  out  FETCH_LEN  window access-fault flags
fetch_offset  in  FETCH_OFF  entries consumed this cycle (0..FETCH_LEN)
jump_vld  in  1  redirect/flush
jump_pc  in  XLEN  redirect target

Behaviour:
- Reset (clk edge with rst=1): queue empty, outstanding=0, drop=0, req_pc=RESET_PC, halted=0. All outputs 0 except imem_addr=RESET_PC.
- Storage: circular buffer with rd_ptr/wr_ptr (clog2(QUEUE_LEN) bits, natural wrap) and count (clog2(QUEUE_LEN)+1 bits).
- Request: imem_req = ~halted & ~jump_vld & (outstanding < MAX_OUTST) & (count + outstanding < QUEUE_LEN). This credit rule guarantees a response never finds the queue full.
- On an issue: req_pc += 4 and outstanding++.
- imem_addr is req_pc (registered); it stays stable while imem_req is held without gnt.
- Response (imem_rvld):
  - If drop>0: discard the response, drop--, outstanding--.
  - Otherwise: write {rdata, resp_pc, err} at wr_ptr, wr_ptr++, outstanding--, resp_pc += 4.
  - If err: the stored instr is 0 and halted is set; no further requests until jump.
- Issue and response in the same cycle: outstanding unchanged.
- Window: fetch_vld[i] = (i < count). Entry i is read combinationally at rd_ptr+i (mod QUEUE_LEN). Entries with i >= count drive instr/pc/err = 0.
- Pop: rd_ptr += fetch_offset and count -= fetch_offset, at the clock edge.
  - fetch_offset > count is illegal; the bench asserts on it and the RTL clamps to count.
  - Push and pop in the same cycle: count += push - pop.
- Latency: a response accepted at edge N is visible in fetch_vld at cycle N+1.
- jump_vld (priority over push, pop and issue):
  - Queue emptied; req_pc = resp_pc = jump_pc; halted=0.
  - drop = outstanding minus any response arriving in the same cycle (that response is discarded).
  - No request is issued in the jump cycle; the first request at jump_pc is issued next cycle.
  - jump_pc[1:0] is ignored (word aligned).
- A jump arriving while drop>0: drop accumulates (drop = outstanding after this cycle).
- rst mid-operation: all state returns to reset values; responses still in flight afterwards must not arrive (the memory is reset on the same rst).

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- When defined: if count==0, drop==0 and imem_rvld & ~jump_vld, the response is also driven on window entry 0 in the same cycle (fetch_vld[0]=1, zero-cycle latency).
  - If fetch_offset>=1 that cycle, the word is consumed and not written.
  - Otherwise it is written as normal.
- When undefined: response-to-window latency is always one cycle; fetch_* depend only on flops.

Decomposition:
- Shared package/define file: XLEN, FETCH_LEN, FETCH_OFF, QUEUE_LEN, entry field widths, RESET_PC.
- One natural sub-module, fetch_queue_ram: QUEUE_LEN x (XLEN+XLEN+1) register array with one write port and FETCH_LEN rotated combinational read ports.
- Request/credit/drop logic stays in the top module.

Test Plan:
- Reset, memory returns one word per cycle, fetch_offset=0 → issue stops after 8 requests (count 8, outstanding 0); fetch_pc = 0x200, 0x204, 0x208, 0x20C; fetch_vld=4'b1111.
- Steady state, fetch_offset=4 every cycle, single-cycle memory → sustained 1 word/cycle; PCs strictly +4, no gaps or duplicates.
- 3 requests outstanding, jump_vld with jump_pc=0x1000 → the 3 late responses are dropped; the next fetch_pc[0] is 0x1000; count is 0 in the jump cycle +1.
- Response at PC 0x20C with imem_err=1 → entry has err=1 and instr=0; imem_req stays low; a jump to 0x300 resumes fetching.
- fetch_offset=2 with a response in the same cycle at count=3 → count becomes 2; window advances by 2 with the new word last.
- With FETCH_QUEUE_BYPASS_EN, empty queue, response 0x00000013 with fetch_offset=1 → fetch_vld[0]=1 the same cycle; count stays 0.
